// File: rtl/jls_pkg.sv
// rtl/jls_pkg.sv - shared widths, code descriptor type and code-string helpers
package jls_pkg;

    localparam int CODE_MAXLEN = 34;
    localparam int MAXBYTES    = 5;
    localparam int ZC_W        = 5;
    localparam int BV_W        = 9;
    localparam int BC_W        = 4;
    localparam int LEN_W       = 6;
    localparam int RES_W       = 7;

    typedef struct packed {
        logic [ZC_W-1:0] zc;
        logic [BV_W-1:0] bv;
        logic [BC_W-1:0] bc;
    } code_t;

    function automatic logic [LEN_W-1:0] code_len(input code_t c);
        return LEN_W'(c.zc) + LEN_W'(c.bc);
    endfunction

    // Unary prefix, terminating '1' and low bc bits of bv, left-aligned with zero fill.
    function automatic logic [CODE_MAXLEN-1:0] code_bits(input code_t c);
        logic [11:0]      one_bit;
        logic [11:0]      tail;
        logic [LEN_W-1:0] len;
        one_bit = 12'd1 << c.bc;
        tail    = one_bit | ({3'b000, c.bv} & (one_bit - 12'd1));
        len     = code_len(c);
        return {22'b0, tail} << (LEN_W'(CODE_MAXLEN) - len);
    endfunction

endpackage

// File: rtl/golomb_byte_packer_byte_extract.sv
// rtl/golomb_byte_packer_byte_extract.sv - appends a code to the residue and cuts stuffed bytes
module byte_extract
    import jls_pkg::*;
(
    input  logic [RES_W-1:0]          res,
    input  logic [2:0]                res_len,
    input  logic [CODE_MAXLEN-1:0]    code,
    input  logic [LEN_W-1:0]          len,
    input  logic                      last_ff,
    output logic [8*MAXBYTES-1:0]     data,
    output logic [2:0]                nb,
    output logic [RES_W-1:0]          next_res,
    output logic [2:0]                next_res_len,
    output logic                      next_last_ff
);

    localparam int STREAM_W = RES_W + CODE_MAXLEN;

    logic [STREAM_W-1:0] stream;
    logic [LEN_W-1:0]    avail;
    logic                ff;
    logic                done;
    logic [7:0]          b;

    // Bits below the valid length are always zero, which gives flush padding for free.
    always_comb begin
        stream = {res, {CODE_MAXLEN{1'b0}}} | ({{RES_W{1'b0}}, code} << (3'd7 - res_len));
        avail  = LEN_W'(res_len) + len;
        ff     = last_ff;
        done   = 1'b0;
        b      = 8'h00;
        data   = '0;
        nb     = 3'd0;
        for (int k = 0; k < MAXBYTES; k++) begin
            if (!done) begin
                if (ff && avail >= 6'd7) begin
                    b      = {1'b0, stream[STREAM_W-1 -: 7]};
                    stream = stream << 7;
                    avail  = avail - 6'd7;
                end else if (!ff && avail >= 6'd8) begin
                    b      = stream[STREAM_W-1 -: 8];
                    stream = stream << 8;
                    avail  = avail - 6'd8;
                end else begin
                    done = 1'b1;
                end
                if (!done) begin
                    data[8*(MAXBYTES-1-k) +: 8] = b;
                    nb = nb + 3'd1;
                    ff = (b == 8'hFF);
                end
            end
        end
        next_res     = stream[STREAM_W-1 -: RES_W];
        next_res_len = avail[2:0];
        next_last_ff = ff;
    end

endmodule

// File: rtl/golomb_byte_packer.sv
// rtl/golomb_byte_packer.sv - two-stage JLS bit packer with 0xFF stuffing and end-of-scan flush
module golomb_byte_packer
    import jls_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_vl,
    input  logic [ZC_W-1:0]       i_zc,
    input  logic [BV_W-1:0]       i_bv,
    input  logic [BC_W-1:0]       i_bc,
    input  logic                  i_flush,
    output logic                  o_vl,
    output logic [2:0]            o_nb,
    output logic [8*MAXBYTES-1:0] o_data,
    output logic                  o_last
);

    code_t                 in_code;
    logic                  has_code;
    logic [CODE_MAXLEN-1:0] s1_code;
    logic [LEN_W-1:0]      s1_len;
    logic                  s1_flush;

    logic [RES_W-1:0]      res;
    logic [2:0]            res_len;
    logic                  last_ff;

    logic [8*MAXBYTES-1:0] ex_data;
    logic [2:0]            ex_nb;
    logic [RES_W-1:0]      ex_res;
    logic [2:0]            ex_res_len;
    logic                  ex_ff;

    logic [7:0]            pad_byte;
    logic [8*MAXBYTES-1:0] nxt_data;
    logic [2:0]            nxt_nb;

    assign in_code  = {i_zc, i_bv, i_bc};
    assign has_code = i_vl && (i_zc != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_code  <= '0;
            s1_len   <= '0;
            s1_flush <= 1'b0;
        end else begin
            s1_code  <= has_code ? code_bits(in_code) : '0;
            s1_len   <= has_code ? code_len(in_code) : '0;
            s1_flush <= i_flush;
        end
    end

    byte_extract u_extract (
        .res          (res),
        .res_len      (res_len),
        .code         (s1_code),
        .len          (s1_len),
        .last_ff      (last_ff),
        .data         (ex_data),
        .nb           (ex_nb),
        .next_res     (ex_res),
        .next_res_len (ex_res_len),
        .next_last_ff (ex_ff)
    );

    // Flush byte lands right after the bytes cut this cycle; after 0xFF it keeps the stuffed 0 MSB.
    always_comb begin
        pad_byte = ex_ff ? {1'b0, ex_res} : {ex_res, 1'b0};
        nxt_data = ex_data;
        nxt_nb   = ex_nb;
        if (s1_flush && (ex_res_len != 3'd0 || ex_ff)) begin
            nxt_data = ex_data | ({(ex_res_len != 3'd0) ? pad_byte : 8'h00, 32'b0} >> {ex_nb, 3'b000});
            nxt_nb   = ex_nb + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res     <= '0;
            res_len <= '0;
            last_ff <= 1'b0;
            o_vl    <= 1'b0;
            o_nb    <= '0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else begin
            if (s1_flush) begin
                res     <= '0;
                res_len <= '0;
                last_ff <= 1'b0;
            end else begin
                res     <= ex_res;
                res_len <= ex_res_len;
                last_ff <= ex_ff;
            end
            o_vl   <= (nxt_nb != 3'd0) || s1_flush;
            o_nb   <= nxt_nb;
            o_data <= nxt_data;
            o_last <= s1_flush;
        end
    end

endmodule
